// File: rtl/msk_byte_serializer.sv
// Masked state-to-byte serializer: takes a full shbit-encoded shared AES state and
// streams it one shared byte per cycle under valid/ready, moving shares without combining them.
module msk_byte_serializer #(
  parameter int D     = 2,
  parameter int COUNT = 16,
  localparam int BYTE_W  = 8 * D,
  localparam int STATE_W = 8 * COUNT * D,
  localparam int IDX_W   = $clog2(COUNT)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [STATE_W-1:0] sh_state_in_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [BYTE_W-1:0]  sh_byte_out_o,
  output logic [IDX_W-1:0]   out_idx_o,
  output logic               out_last_o
);

  typedef enum logic {IDLE, SEND} state_e;

  state_e               state_q;
  logic [STATE_W-1:0]   buf_q;
  logic [IDX_W-1:0]     cnt_q;

  logic                 load;
  logic                 xfer;
  logic [STATE_W-1:0]   buf_shift_d;

  assign sh_byte_out_o = buf_q[0 +: BYTE_W];
  assign out_idx_o     = cnt_q;
  assign out_valid_o   = (state_q == SEND);
  assign out_last_o    = out_valid_o && (cnt_q == IDX_W'(COUNT - 1));
  assign xfer          = out_valid_o && out_ready_i;
  assign in_ready_o    = (state_q == IDLE) || (xfer && out_last_o);
  assign load          = in_valid_i && in_ready_o;

  // Whole shared byte slots move down together; zeros fill the top so no stale shares linger.
  assign buf_shift_d = {{BYTE_W{1'b0}}, buf_q[STATE_W-1:BYTE_W]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
    end else if (load) begin
      state_q <= SEND;
      buf_q   <= sh_state_in_i;
      cnt_q   <= '0;
    end else if (xfer) begin
      buf_q <= buf_shift_d;
      if (out_last_o) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_msk_byte_serializer.sv
// Directed bench for msk_byte_serializer: a d=2/count=16 instance for streaming, stall,
// back-to-back and reset cases, and a d=3/count=4 instance for share ordering.
module tb_msk_byte_serializer;
  localparam int DA = 2, CA = 16, BA = 8 * DA;
  localparam int DB = 3, CB = 4,  BB = 8 * DB;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic a_iv, a_ir, a_ov, a_or, a_last;
  logic [CA*BA-1:0] a_st;
  logic [BA-1:0]    a_byte;
  logic [3:0]       a_idx;

  logic b_iv, b_ir, b_ov, b_or, b_last;
  logic [CB*BB-1:0] b_st;
  logic [BB-1:0]    b_byte;
  logic [1:0]       b_idx;

  msk_byte_serializer #(.D(DA), .COUNT(CA)) u_a (
    .clk_i(clk), .rst_i(rst), .in_valid_i(a_iv), .in_ready_o(a_ir),
    .sh_state_in_i(a_st), .out_valid_o(a_ov), .out_ready_i(a_or),
    .sh_byte_out_o(a_byte), .out_idx_o(a_idx), .out_last_o(a_last));

  msk_byte_serializer #(.D(DB), .COUNT(CB)) u_b (
    .clk_i(clk), .rst_i(rst), .in_valid_i(b_iv), .in_ready_o(b_ir),
    .sh_state_in_i(b_st), .out_valid_o(b_ov), .out_ready_i(b_or),
    .sh_byte_out_o(b_byte), .out_idx_o(b_idx), .out_last_o(b_last));

  int checks = 0;
  int errors = 0;
  int vcnt   = 0;

  typedef struct {
    logic        iv;
    logic        ordy;
    logic [22:0] exp;
  } vec_t;

  vec_t tbl[18];

  function automatic logic [15:0] ilv2(input logic [7:0] s0, input logic [7:0] s1);
    logic [15:0] r;
    for (int b = 0; b < 8; b++) begin
      r[2*b]   = s0[b];
      r[2*b+1] = s1[b];
    end
    return r;
  endfunction

  function automatic logic [23:0] ilv3(input logic [7:0] s0, input logic [7:0] s1,
                                       input logic [7:0] s2);
    logic [23:0] r;
    for (int b = 0; b < 8; b++) begin
      r[3*b]   = s0[b];
      r[3*b+1] = s1[b];
      r[3*b+2] = s2[b];
    end
    return r;
  endfunction

  // share0 = base+k, share1 = constant
  function automatic logic [CA*BA-1:0] mk_a(input logic [7:0] base, input logic [7:0] c1);
    logic [CA*BA-1:0] s;
    for (int k = 0; k < CA; k++) s[BA*k +: BA] = ilv2(base + 8'(k), c1);
    return s;
  endfunction

  function automatic logic [CB*BB-1:0] mk_b();
    logic [CB*BB-1:0] s;
    for (int k = 0; k < CB; k++) s[BB*k +: BB] = ilv3(8'(k), 8'hA5, 8'h3C ^ 8'(k));
    return s;
  endfunction

  task automatic step_a(input logic iv, input logic [CA*BA-1:0] st, input logic ordy,
                        input logic [22:0] exp, input string nm);
    logic [22:0] act;
    @(negedge clk);
    a_iv = iv; a_st = st; a_or = ordy;
    #1;
    act = {a_ov, a_ir, a_idx, a_last, a_byte};
    if (a_ov) vcnt++;
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got {v,rdy,idx,last,byte}=%h expected %h", nm, act, exp);
    end
  endtask

  task automatic step_b(input logic iv, input logic ordy, input logic [28:0] exp,
                        input string nm);
    logic [28:0] act;
    @(negedge clk);
    b_iv = iv; b_st = mk_b(); b_or = ordy;
    #1;
    act = {b_ov, b_ir, b_idx, b_last, b_byte};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got {v,rdy,idx,last,byte}=%h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [22:0] ea(input int k, input logic [7:0] base, input logic [7:0] c1);
    return {1'b1, (k == CA-1), 4'(k), (k == CA-1), ilv2(base + 8'(k), c1)};
  endfunction

  localparam logic [22:0] IDLE_A = {1'b0, 1'b1, 4'd0, 1'b0, 16'h0};
  localparam logic [28:0] IDLE_B = {1'b0, 1'b1, 2'd0, 1'b0, 24'h0};

  initial begin
    logic [CA*BA-1:0] s1, s2;
    s1 = mk_a(8'h00, 8'hA5);
    s2 = mk_a(8'hF0, 8'h3C);

    tbl[0] = '{iv: 1'b1, ordy: 1'b1, exp: IDLE_A};
    for (int k = 0; k < CA; k++) tbl[k+1] = '{iv: 1'b0, ordy: 1'b1, exp: ea(k, 8'h00, 8'hA5)};
    tbl[17] = '{iv: 1'b0, ordy: 1'b1, exp: IDLE_A};

    rst = 1'b1;
    a_iv = 1'b0; a_or = 1'b0; a_st = '0;
    b_iv = 1'b0; b_or = 1'b0; b_st = '0;
    repeat (2) @(posedge clk);
    step_a(1'b0, '0, 1'b0, IDLE_A, "reset_state");
    rst = 1'b0;

    // Basic stream, driven from the vector table
    for (int i = 0; i < 18; i++) step_a(tbl[i].iv, s1, tbl[i].ordy, tbl[i].exp, "basic");
    checks++;
    if (u_a.buf_q !== '0) begin
      errors++;
      $display("FAIL idle_buf_clear got %h expected 0", u_a.buf_q);
    end

    // Back-pressure: three stall cycles at idx 4
    step_a(1'b1, s1, 1'b1, IDLE_A, "bp_load");
    vcnt = 0;
    for (int k = 0; k < CA; k++) begin
      if (k == 4)
        repeat (3) step_a(1'b0, s1, 1'b0, {1'b1, 1'b0, 4'd4, 1'b0, ilv2(8'h04, 8'hA5)}, "bp_hold");
      step_a(1'b0, s1, 1'b1, ea(k, 8'h00, 8'hA5), "bp_stream");
    end
    checks++;
    if (vcnt != 19) begin
      errors++;
      $display("FAIL bp_valid_cycles got %0d expected 19", vcnt);
    end
    step_a(1'b0, s1, 1'b1, IDLE_A, "bp_idle");

    // Back-to-back with next state offered throughout; stall at idx 7 must ignore it
    step_a(1'b1, s1, 1'b1, IDLE_A, "b2b_load");
    for (int k = 0; k < CA; k++) begin
      if (k == 7)
        step_a(1'b1, s2, 1'b0, {1'b1, 1'b0, 4'd7, 1'b0, ilv2(8'h07, 8'hA5)}, "ignored_load");
      step_a(1'b1, s2, 1'b1, ea(k, 8'h00, 8'hA5), "b2b_first");
    end
    for (int k = 0; k < CA; k++) step_a(1'b0, s2, 1'b1, ea(k, 8'hF0, 8'h3C), "b2b_second");
    step_a(1'b0, s2, 1'b1, IDLE_A, "b2b_idle");

    // Reset mid-SEND after five bytes
    step_a(1'b1, s1, 1'b1, IDLE_A, "mid_load");
    for (int k = 0; k < 5; k++) step_a(1'b0, s1, 1'b1, ea(k, 8'h00, 8'hA5), "mid_stream");
    rst = 1'b1;
    step_a(1'b0, s1, 1'b1, IDLE_A, "mid_rst1");
    step_a(1'b0, s1, 1'b1, IDLE_A, "mid_rst2");
    rst = 1'b0;
    repeat (3) step_a(1'b0, s1, 1'b1, IDLE_A, "no_emit");

    // d=3, count=4: two passes to see out_idx wrap
    for (int p = 0; p < 2; p++) begin
      step_b(1'b1, 1'b1, IDLE_B, "sw_load");
      for (int k = 0; k < CB; k++)
        step_b(1'b0, 1'b1, {1'b1, (k == CB-1), 2'(k), (k == CB-1),
                            ilv3(8'(k), 8'hA5, 8'h3C ^ 8'(k))}, "sweep");
      step_b(1'b0, 1'b1, IDLE_B, "sw_idle");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
